// File: rtl/nesoi_video_pkg.sv
// Shared video types and constants: phase encoding, default 640x480@60 timing and
// the colour-bar table used by the optional test pattern.
package nesoi_video_pkg;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CNT_W    = 10;

  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and its consumer (slave).
// The rgb signal exists only when NESOI_TEST_PATTERN_EN is defined.
interface video_timing_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic             en;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
`ifdef NESOI_TEST_PATTERN_EN
  logic [23:0]      rgb;
`endif

  modport master (
    input  en,
    output hsync, vsync, de, x, y, line_start, frame_start
`ifdef NESOI_TEST_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    output en,
    input  hsync, vsync, de, x, y, line_start, frame_start
`ifdef NESOI_TEST_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE/FP/SYNC/BP phase FSM.
// wrap flags the terminal count, so a step taken while wrap=1 returns the counter to 0.
module timing_axis
  import nesoi_video_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output phase_e       phase,
  output logic         wrap
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;
  phase_e       phase_q;

  assign wrap  = (cnt_q == LAST);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
  assign cnt   = cnt_q;
  assign phase = phase_q;

  // Transitions look at the next count so the phase always matches the counter it sits beside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= LAST;
      phase_q <= (BP != 0) ? PH_BP : PH_SYNC;
    end else if (step) begin
      cnt_q <= cnt_d;
      unique case (phase_q)
        PH_ACTIVE: if (cnt_d == FP_START) phase_q <= (FP != 0) ? PH_FP : PH_SYNC;
        PH_FP:     if (cnt_d == SYNC_START) phase_q <= PH_SYNC;
        PH_SYNC: begin
          // With BP == 0 the sync phase ends on the wrap itself.
          if (cnt_d == '0)            phase_q <= PH_ACTIVE;
          else if (cnt_d == BP_START) phase_q <= PH_BP;
        end
        PH_BP:     if (cnt_d == '0) phase_q <= PH_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (default VESA 640x480@60) feeding the HDMI encoder.
// Define NESOI_TEST_PATTERN_EN to add the 8-bar colour test pattern on rgb.
module video_timing_gen
  import nesoi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  video_timing_gen_if.master vid
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             started_q;
  logic             de_int;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (CNT_W)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (vid.en),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (CNT_W)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (vid.en & h_wrap),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Counters park at the last position in reset; outputs stay idle until the first step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q <= 1'b0;
    end else if (vid.en) begin
      started_q <= 1'b1;
    end
  end

  assign de_int          = started_q && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign vid.de          = de_int;
  assign vid.hsync       = (started_q && (h_phase == PH_SYNC)) ? HS_POL : ~HS_POL;
  assign vid.vsync       = (started_q && (v_phase == PH_SYNC)) ? VS_POL : ~VS_POL;
  assign vid.x           = started_q ? h_cnt : '0;
  assign vid.y           = started_q ? v_cnt : '0;
  assign vid.line_start  = started_q && (h_cnt == '0);
  assign vid.frame_start = started_q && (h_cnt == '0) && (v_cnt == '0);

`ifdef NESOI_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [CNT_W-1:0] bar_raw;
  logic [2:0]       bar_idx;

  always_comb begin
    bar_raw = h_cnt / CNT_W'(BAR_W);
    bar_idx = (bar_raw > CNT_W'(7)) ? 3'd7 : bar_raw[2:0];
  end

  assign vid.rgb = de_int ? bar_color(bar_idx) : 24'h000000;
`endif

endmodule
